// File: rtl/ps2_stim_gen.sv
// PS/2 device-side stimulus generator: byte FIFO feeding an 11-bit frame serialiser.
// Define PS2_STIM_PERR_EN to add the inj_parity_err port for parity-error injection.
module ps2_stim_gen #(
  parameter int DEPTH    = 8,
  parameter int HALF_DIV = 4,
  parameter int GAP      = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ps2_clk,
  output logic             ps2_dat,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
`ifdef PS2_STIM_PERR_EN
  ,
  input  logic             inj_parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * HALF_DIV);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] HALF      = CW'(HALF_DIV);
  localparam logic [CW-1:0] CELL_LAST = CW'(2 * HALF_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic [10:0]     r_shift;
  logic [3:0]      r_bit;
  logic [CW-1:0]   r_cyc;
  logic [GW-1:0]   r_gap;
  logic [CNT_W-1:0] r_frames;
  logic            r_clk;
  logic            r_dat;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_done;
  logic            w_clk_nxt;
  logic            w_dat_nxt;
  logic [7:0]      w_rd;
  logic            w_par;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_rd    = r_mem[r_rptr];

`ifdef PS2_STIM_PERR_EN
  assign w_par = ~^w_rd ^ inj_parity_err;
`else
  assign w_par = ~^w_rd;
`endif

  assign in_ready    = !w_full;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign frames_sent = r_frames;
  assign ps2_clk     = r_clk;
  assign ps2_dat     = r_dat;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    w_clk_nxt = 1'b1;
    w_dat_nxt = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_clk_nxt = (r_cyc < HALF);
        w_dat_nxt = r_shift[0];
        if (r_cyc == CELL_LAST && r_bit == 4'd10) begin
          w_done = 1'b1;
          w_next = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lines are registered copies of the FSM's view, so they lag it by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_bit    <= '0;
      r_cyc    <= '0;
      r_gap    <= '0;
      r_frames <= '0;
      r_clk    <= 1'b1;
      r_dat    <= 1'b1;
    end else begin
      r_clk <= w_clk_nxt;
      r_dat <= w_dat_nxt;
      if (w_pop) begin
        r_shift <= {1'b1, w_par, w_rd, 1'b0};
        r_bit   <= '0;
        r_cyc   <= '0;
      end else if (r_state == S_SHIFT) begin
        if (r_cyc == CELL_LAST) begin
          r_cyc   <= '0;
          r_bit   <= r_bit + 4'd1;
          r_shift <= {1'b1, r_shift[10:1]};
        end else begin
          r_cyc <= r_cyc + CW'(1);
        end
      end
      if (r_state == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end else begin
        r_gap <= '0;
      end
      if (w_done) begin
        r_frames <= r_frames + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_stim_gen.sv
// Randomised and directed bench for ps2_stim_gen against a frame-timing reference model.
// Falling-edge receiver decodes every frame and checks it against the popped byte order.
module tb_ps2_stim_gen;

  localparam int DEPTH    = 8;
  localparam int HALF_DIV = 4;
  localparam int GAP      = 16;
  localparam int CNT_W    = 16;
  localparam int FLEN     = 22 * HALF_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             inj = 1'b0;
  logic             in_ready;
  logic             ps2_clk;
  logic             ps2_dat;
  logic             busy;
  logic [CNT_W-1:0] frames_sent;

  always #5 clk = ~clk;

  ps2_stim_gen #(
    .DEPTH(DEPTH), .HALF_DIV(HALF_DIV), .GAP(GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .busy(busy),
    .frames_sent(frames_sent)
`ifdef PS2_STIM_PERR_EN
    ,
    .inj_parity_err(inj)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       perr;
  } frm_t;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] byte_q [$];
  frm_t       sent_q [$];
  logic [10:0] rx_hist [$];
  int         rx_start [$];
  int         ecnt = 0;
  int         idle_from = 0;
  int         act_p = 0;
  bit         act = 0;
  logic [10:0] act_bits = '0;
  int         mfr = 0;
  bit         m_push = 0;
  logic       prev_clk = 1'b1;
  int         rx_n = 0;
  logic [10:0] rx_bits = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ecnt, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic perr);
    logic p;
    p = (($countones(d) % 2) == 0) ^ perr;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic step();
    logic [7:0] b;
    frm_t f;
    int k;
    logic eclk, edat, perr;
    bit pop, push;
    @(negedge clk);
    ecnt++;
    m_push = 0;
    if (reset) begin
      byte_q.delete();
      sent_q.delete();
      act = 0;
      mfr = 0;
      idle_from = ecnt;
    end else begin
      pop  = (ecnt - 1 >= idle_from) && (byte_q.size() > 0);
      push = in_valid && (byte_q.size() < DEPTH);
`ifdef PS2_STIM_PERR_EN
      perr = inj;
`else
      perr = 1'b0;
`endif
      if (pop) begin
        b = byte_q.pop_front();
        act = 1;
        act_p = ecnt;
        act_bits = frame_of(b, perr);
        idle_from = ecnt + FLEN + GAP;
        sent_q.push_back('{b, perr});
      end
      if (push) byte_q.push_back(in_data);
      m_push = push;
      if (act && ecnt == act_p + FLEN) mfr++;
    end
    eclk = 1'b1;
    edat = 1'b1;
    if (act && !reset && ecnt > act_p && ecnt <= act_p + FLEN) begin
      k = ecnt - act_p - 1;
      eclk = (k % (2 * HALF_DIV)) < HALF_DIV;
      edat = act_bits[k / (2 * HALF_DIV)];
    end
    chk("ps2_clk", 32'(ps2_clk), 32'(eclk));
    chk("ps2_dat", 32'(ps2_dat), 32'(edat));
    chk("in_ready", 32'(in_ready), 32'(byte_q.size() < DEPTH));
    chk("busy", 32'(busy), 32'((ecnt < idle_from) || (byte_q.size() > 0)));
    chk("frames", 32'(frames_sent), 32'(mfr % (1 << CNT_W)));
    if (reset) begin
      prev_clk = 1'b1;
      rx_n = 0;
    end else begin
      if (prev_clk && !ps2_clk) begin
        if (rx_n == 0) rx_start.push_back(ecnt);
        rx_bits[rx_n] = ps2_dat;
        rx_n++;
        if (rx_n == 11) begin
          rx_n = 0;
          rx_hist.push_back(rx_bits);
          if (sent_q.size() == 0) begin
            chk("rx_extra", 32'(1), 32'(0));
          end else begin
            f = sent_q.pop_front();
            chk("rx_frame", 32'(rx_bits), 32'(frame_of(f.d, f.perr)));
          end
        end
      end
      prev_clk = ps2_clk;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push1(input logic [7:0] d);
    in_data = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while (busy && i < bound) begin
      step();
      i++;
    end
    chk("drain", 32'(busy), 32'(0));
  endtask

  initial begin
    int pe, rs, h, nacc, i;
    bit got9;

    run(3);
    reset = 1'b0;
    chk("rst_frames", 32'(frames_sent), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    run(5);

    push1(8'h1C);
    pe = ecnt;
    run(FLEN + GAP + 4);
    chk("lat_fall", 32'(rx_start[rx_start.size() - 1] - pe), 32'(2 + HALF_DIV));
    chk("bits_1c", 32'(rx_hist[rx_hist.size() - 1]), 32'(11'h438));
    chk("frames_1", 32'(frames_sent), 32'(1));

    push1(8'h00);
    push1(8'hF0);
    push1(8'h01);
    drain(2000);
    h = rx_hist.size();
    chk("par_00", 32'(rx_hist[h - 3][9]), 32'(1));
    chk("par_f0", 32'(rx_hist[h - 2][9]), 32'(1));
    chk("par_01", 32'(rx_hist[h - 1][9]), 32'(0));

    rs = rx_start.size();
    push1(8'hE0);
    push1(8'h75);
    push1(8'hF0);
    drain(2000);
    chk("period1", 32'(rx_start[rs + 1] - rx_start[rs]), 32'(FLEN + GAP + 1));
    chk("period2", 32'(rx_start[rs + 2] - rx_start[rs + 1]), 32'(FLEN + GAP + 1));

    push1(8'h55);
    run(3);
    nacc = 0;
    in_valid = 1'b1;
    for (i = 0; i < 20; i++) begin
      in_data = 8'h80 + 8'(nacc);
      step();
      if (m_push) nacc++;
      if (!in_ready) break;
    end
    chk("fill_cnt", 32'(nacc), 32'(DEPTH));
    in_data = 8'h80 + 8'(nacc);
    got9 = 0;
    for (i = 0; i < 300 && !got9; i++) begin
      step();
      got9 = m_push;
    end
    in_valid = 1'b0;
    chk("ninth", 32'(got9), 32'(1));
    drain(3000);

`ifdef PS2_STIM_PERR_EN
    in_data = 8'h1C;
    in_valid = 1'b1;
    inj = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    inj = 1'b0;
    drain(2000);
    h = rx_hist.size();
    chk("perr_inj", 32'(rx_hist[h - 2][9]), 32'(1));
    chk("perr_next", 32'(rx_hist[h - 1][9]), 32'(0));
`endif

    for (i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 5) == 0);
      in_data = 8'($urandom);
      inj = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    inj = 1'b0;
    drain(3000);

    push1(8'hA4);
    run(13);
    #2 reset = 1'b1;
    #1;
    chk("arst_clk", 32'(ps2_clk), 32'(1));
    chk("arst_dat", 32'(ps2_dat), 32'(1));
    chk("arst_frames", 32'(frames_sent), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    run(2);
    reset = 1'b0;
    run(150);
    push1(8'h3C);
    drain(2000);
    chk("post_rst", 32'(frames_sent), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
